// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and default widths for the run sequencer
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      RC_IDLE,
      RC_LOAD,
      RC_START,
      RC_RUN,
      RC_READ
   } rc_state_t;

   localparam int RC_AW    = 8;
   localparam int RC_DW    = 8;
   localparam int RC_CNT_W = 16;

endpackage

// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - preload stream, data-memory port and readback stream of the run sequencer
interface run_controller_if
   import run_ctrl_pkg::*;
#(
   parameter int AW = RC_AW,
   parameter int DW = RC_DW
);

   logic          host_wr_valid;
   logic          host_wr_ready;
   logic [AW-1:0] host_wr_addr;
   logic [DW-1:0] host_wr_data;
   logic          host_wr_last;

   logic          mem_own;
   logic [AW-1:0] mem_addr;
   logic          mem_wr_en;
   logic [DW-1:0] mem_wr_data;
   logic          mem_rd_en;
   logic [DW-1:0] mem_rd_data;

   logic          res_valid;
   logic          res_ready;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_data;
   logic          res_last;

   modport master (
      input  host_wr_valid, host_wr_addr, host_wr_data, host_wr_last,
      output host_wr_ready,
      output mem_own, mem_addr, mem_wr_en, mem_wr_data, mem_rd_en,
      input  mem_rd_data,
      output res_valid, res_addr, res_data, res_last,
      input  res_ready
   );

   modport slave (
      output host_wr_valid, host_wr_addr, host_wr_data, host_wr_last,
      input  host_wr_ready,
      input  mem_own, mem_addr, mem_wr_en, mem_wr_data, mem_rd_en,
      output mem_rd_data,
      input  res_valid, res_addr, res_data, res_last,
      output res_ready
   );

endinterface

// File: rtl/run_timer.sv
// rtl/run_timer.sv - saturating RUN-cycle counter with a terminal compare against a fixed limit
module run_timer
   import run_ctrl_pkg::*;
#(
   parameter logic [RC_CNT_W-1:0] LIMIT = 16'd50000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   output logic [RC_CNT_W-1:0] count,
   output logic                term
);

   localparam logic [RC_CNT_W-1:0] CNT_MAX = '1;

   logic [RC_CNT_W-1:0] count_inc;

   assign count_inc = (count == CNT_MAX) ? count : count + RC_CNT_W'(1);

   // term flags the enabled cycle that brings the count up to LIMIT
   assign term = en && (count_inc == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count_inc;
      end
   end

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - host run sequencer: preload, START/DONE run under timeout, readback window
// Optional: define RUN_CTRL_CYCLE_CNT_EN to expose the RUN cycle count on cycle_count.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int                  START_CYCLES = 2,
   parameter logic [RC_CNT_W-1:0] TIMEOUT      = 16'd50000,
   parameter int                  AW           = RC_AW,
   parameter int                  DW           = RC_DW
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                host_go,
   input  logic [AW-1:0]       rd_base,
   input  logic [AW:0]         rd_count,
   run_controller_if.master    bus,
   output logic                dut_start,
   input  logic                dut_done,
   output logic                busy,
   output logic                run_done,
   output logic                timeout,
   output logic [RC_CNT_W-1:0] cycle_count
);

   localparam int            SW      = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [SW-1:0] ST_LAST = SW'(START_CYCLES - 1);
   localparam logic [AW:0]   IDX_ONE = (AW + 1)'(1);

   rc_state_t           state, state_nxt;
   logic [AW-1:0]       base_q;
   logic [AW:0]         count_q;
   logic [AW:0]         idx;
   logic [SW-1:0]       st_cnt;
   logic [AW-1:0]       rd_addr;
   logic [DW-1:0]       rd_word;
   logic                go_take, wr_take, rd_take, rd_last;
   logic                tmr_term;
   logic [RC_CNT_W-1:0] tmr_count;

   assign go_take = (state == RC_IDLE) && host_go;
   assign wr_take = (state == RC_LOAD) && bus.host_wr_valid && bus.host_wr_last;
   assign rd_take = (state == RC_READ) && bus.res_ready;
   assign rd_last = (idx == count_q - IDX_ONE);
   assign rd_addr = base_q + idx[AW-1:0];
   assign rd_word = bus.mem_rd_data;
   assign busy    = (state != RC_IDLE);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= RC_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      dut_start         = 1'b0;
      bus.host_wr_ready = 1'b0;
      bus.mem_own       = 1'b1;
      bus.mem_addr      = '0;
      bus.mem_wr_en     = 1'b0;
      bus.mem_wr_data   = '0;
      bus.mem_rd_en     = 1'b0;
      bus.res_valid     = 1'b0;
      bus.res_addr      = '0;
      bus.res_data      = '0;
      bus.res_last      = 1'b0;
      case (state)
         RC_IDLE: begin
            if (host_go) state_nxt = RC_LOAD;
         end
         RC_LOAD: begin
            bus.host_wr_ready = 1'b1;
            bus.mem_wr_en     = bus.host_wr_valid;
            bus.mem_addr      = bus.host_wr_addr;
            bus.mem_wr_data   = bus.host_wr_data;
            if (wr_take) state_nxt = RC_START;
         end
         RC_START: begin
            dut_start = 1'b1;
            if (st_cnt == ST_LAST) state_nxt = RC_RUN;
         end
         RC_RUN: begin
            bus.mem_own = 1'b0;
            // done takes priority over a timeout landing in the same cycle
            if (dut_done) begin
               state_nxt = (count_q == '0) ? RC_IDLE : RC_READ;
            end else if (tmr_term) begin
               state_nxt = RC_IDLE;
            end
         end
         RC_READ: begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = rd_addr;
            bus.res_valid = 1'b1;
            bus.res_addr  = rd_addr;
            bus.res_data  = rd_word;
            bus.res_last  = rd_last;
            if (rd_take && rd_last) state_nxt = RC_IDLE;
         end
         default: state_nxt = RC_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         base_q   <= '0;
         count_q  <= '0;
         idx      <= '0;
         st_cnt   <= '0;
         timeout  <= 1'b0;
         run_done <= 1'b0;
      end else begin
         run_done <= (state != RC_IDLE) && (state_nxt == RC_IDLE);
         st_cnt   <= (state == RC_START) ? st_cnt + SW'(1) : '0;
         if (go_take) begin
            base_q  <= rd_base;
            count_q <= rd_count;
            timeout <= 1'b0;
         end
         if ((state == RC_RUN) && !dut_done && tmr_term) begin
            timeout <= 1'b1;
         end
         if (state != RC_READ) begin
            idx <= '0;
         end else if (rd_take) begin
            idx <= idx + IDX_ONE;
         end
      end
   end

   run_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clk   (CLK),
      .rst   (reset),
      .clr   (go_take),
      .en    (state == RC_RUN),
      .count (tmr_count),
      .term  (tmr_term)
   );

`ifdef RUN_CTRL_CYCLE_CNT_EN
   assign cycle_count = tmr_count;
`else
   logic unused_tmr_count;
   assign unused_tmr_count = ^tmr_count;
   assign cycle_count      = '0;
`endif

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - randomized scoreboard bench for run_controller
module tb_run_controller;
   import run_ctrl_pkg::*;

   localparam int AW  = 8;
   localparam int DW  = 8;
   localparam int SC  = 2;
   localparam int TMO = 20;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic          CLK = 1'b0;
   logic          reset;
   logic          host_go;
   logic [AW-1:0] rd_base;
   logic [AW:0]   rd_count;
   logic          dut_start;
   logic          dut_done;
   logic          busy;
   logic          run_done;
   logic          timeout;
   logic [15:0]   cycle_count;

   run_controller_if #(.AW(AW), .DW(DW)) bus ();

   run_controller #(
      .START_CYCLES (SC),
      .TIMEOUT      (16'(TMO)),
      .AW           (AW),
      .DW           (DW)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .host_go     (host_go),
      .rd_base     (rd_base),
      .rd_count    (rd_count),
      .bus         (bus),
      .dut_start   (dut_start),
      .dut_done    (dut_done),
      .busy        (busy),
      .run_done    (run_done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   always #5 CLK = ~CLK;

   // external data memory with combinational read
   logic [DW-1:0] mem [256];
   always @(posedge CLK) begin
      if (bus.mem_own && bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
   end
   assign bus.mem_rd_data = mem[bus.mem_addr];

   logic [DW-1:0] ref_mem [256];
   word_t sb[$];
   word_t pre[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cnt_start = 0, cnt_run = 0, cnt_wr = 0, cnt_words = 0, cnt_done = 0;
   int ready_mode = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic int exp_cc(input int r);
`ifdef RUN_CTRL_CYCLE_CNT_EN
      return r;
`else
      return 0 * r;
`endif
   endfunction

   // monitor: activity counters, stall stability and scoreboard pops
   initial begin
      bit    stall;
      word_t held, w;
      stall = 1'b0;
      held  = '0;
      forever begin
         @(negedge CLK);
         if (dut_start) cnt_start++;
         if (!bus.mem_own) cnt_run++;
         if (bus.mem_wr_en) cnt_wr++;
         if (run_done) cnt_done++;
         if (stall && bus.res_valid) begin
            check("stall_addr", 32'(bus.res_addr), 32'(held.addr));
            check("stall_data", 32'(bus.res_data), 32'(held.data));
         end
         if (bus.res_valid && bus.res_ready) begin
            cnt_words++;
            check("word_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               w = sb.pop_front();
               check("res_addr", 32'(bus.res_addr), 32'(w.addr));
               check("res_data", 32'(bus.res_data), 32'(w.data));
               check("res_last", 32'(bus.res_last), 32'(w.last));
            end
         end
         stall     = bus.res_valid && !bus.res_ready;
         held.addr = bus.res_addr;
         held.data = bus.res_data;
         held.last = bus.res_last;
      end
   end

   initial begin
      bus.res_ready = 1'b1;
      forever begin
         @(posedge CLK);
         #1;
         case (ready_mode)
            1:       bus.res_ready = ~bus.res_ready;
            2:       bus.res_ready = 1'($urandom_range(0, 1));
            default: bus.res_ready = 1'b1;
         endcase
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      if (busy) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: busy %0d after %0d cycles, required 0", name, busy, n);
      end
   endtask

   task automatic add_pre(input logic [AW-1:0] a, input logic [DW-1:0] d);
      word_t w;
      w.addr = a;
      w.data = d;
      w.last = 1'b0;
      pre.push_back(w);
   endtask

   task automatic make_pre(input logic [AW-1:0] base, input int count);
      pre.delete();
      if ($urandom_range(0, 1) == 1) add_pre(AW'($urandom), DW'($urandom));
      for (int i = 0; i < count; i++) add_pre(AW'(int'(base) + i), DW'($urandom));
      if (count == 0) add_pre(AW'($urandom), DW'($urandom));
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_dut_start"}, 32'(dut_start), 0);
      check({tag, "_mem_own"}, 32'(bus.mem_own), 1);
      check({tag, "_run_done"}, 32'(run_done), 0);
      check({tag, "_res_valid"}, 32'(bus.res_valid), 0);
      check({tag, "_mem_wr_en"}, 32'(bus.mem_wr_en), 0);
      check({tag, "_mem_rd_en"}, 32'(bus.mem_rd_en), 0);
      check({tag, "_wr_ready"}, 32'(bus.host_wr_ready), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
      check({tag, "_cycle_count"}, 32'(cycle_count), 0);
   endtask

   // issue go, stream the preload list, and queue the expected readback
   task automatic go_and_load(input logic [AW-1:0] base, input int count, input int delay);
      int    ew;
      word_t w;
      wait_idle("pre_go_idle");
      rd_base  = base;
      rd_count = (AW + 1)'(count);
      host_go  = 1'b1;
      tick();
      host_go  = 1'b0;
      rd_base  = AW'($urandom);
      rd_count = (AW + 1)'($urandom);
      check("go_busy", 32'(busy), 1);
      check("go_timeout_clr", 32'(timeout), 0);
      check("go_cycle_count_clr", 32'(cycle_count), 0);
      check("load_wr_ready", 32'(bus.host_wr_ready), 1);
      for (int i = 0; i < pre.size(); i++) begin
         bus.host_wr_valid = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         bus.host_wr_valid = 1'b1;
         bus.host_wr_addr  = pre[i].addr;
         bus.host_wr_data  = pre[i].data;
         bus.host_wr_last  = (i == pre.size() - 1);
         ref_mem[pre[i].addr] = pre[i].data;
         tick();
      end
      bus.host_wr_valid = 1'b0;
      bus.host_wr_last  = 1'b0;
      ew = (delay > TMO || count == 0) ? 0 : count;
      for (int i = 0; i < ew; i++) begin
         w.addr = AW'(int'(base) + i);
         w.data = ref_mem[w.addr];
         w.last = (i == ew - 1);
         sb.push_back(w);
      end
   endtask

   task automatic run(input logic [AW-1:0] base, input int count, input int delay,
                      input bit in_start, input bit poke);
      int s_start, s_run, s_wr, s_words, s_done, n, exp_run, exp_words;
      bit tmo;
      wait_idle("pre_run_idle");
      s_start = cnt_start; s_run = cnt_run; s_wr = cnt_wr; s_words = cnt_words; s_done = cnt_done;
      go_and_load(base, count, delay);
      tmo       = (delay > TMO);
      exp_run   = tmo ? TMO : delay;
      exp_words = (tmo || count == 0) ? 0 : count;
      if (in_start) dut_done = 1'b1;
      n = 0;
      while (bus.mem_own && n < 20) begin
         tick();
         n++;
      end
      n = 1;
      while (!bus.mem_own && n <= TMO + 5) begin
         dut_done = (n == delay) || (in_start && n <= delay);
         if (poke) begin
            host_go = (n == 1);
            rd_base = AW'($urandom);
         end
         tick();
         n++;
      end
      dut_done = 1'b0;
      host_go  = 1'b0;
      wait_idle("run_idle");
      tick();
      check("preload_writes", 32'(cnt_wr - s_wr), 32'(pre.size()));
      check("start_cycles", 32'(cnt_start - s_start), SC);
      check("run_cycles", 32'(cnt_run - s_run), 32'(exp_run));
      check("timeout_flag", 32'(timeout), 32'(tmo));
      check("cycle_count", 32'(cycle_count), 32'(exp_cc(exp_run)));
      check("run_done_pulses", 32'(cnt_done - s_done), 1);
      check("words_streamed", 32'(cnt_words - s_words), 32'(exp_words));
      check("sb_drained", 32'(sb.size()), 0);
      sb.delete();
   endtask

   initial begin
      int s_done, s_words, n, cnt, dly;
      bit ins, pk;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      reset = 1'b1;
      host_go = 1'b0;
      rd_base = '0;
      rd_count = '0;
      dut_done = 1'b0;
      bus.host_wr_valid = 1'b0;
      bus.host_wr_addr = '0;
      bus.host_wr_data = '0;
      bus.host_wr_last = 1'b0;
      repeat (3) tick();
      reset_checks("reset");
      reset = 1'b0;
      tick();

      // seed the whole memory so every window read has a known value
      pre.delete();
      for (int i = 0; i < 256; i++) add_pre(AW'(i), DW'($urandom));
      run(8'h00, 0, 2, 1'b0, 1'b0);

      pre.delete();
      add_pre(8'h10, 8'hAA); add_pre(8'h11, 8'hBB); add_pre(8'h12, 8'hCC); add_pre(8'h13, 8'hDD);
      run(8'h10, 4, 7, 1'b0, 1'b0);

      ready_mode = 1;
      make_pre(8'h40, 6);
      run(8'h40, 6, 5, 1'b0, 1'b0);
      ready_mode = 0;

      pre.delete();
      add_pre(8'hFE, 8'h11); add_pre(8'hFF, 8'h22); add_pre(8'h00, 8'h33);
      run(8'hFE, 3, 4, 1'b0, 1'b0);

      make_pre(8'h20, 0);
      run(8'h20, 0, 3, 1'b0, 1'b0);

      make_pre(8'h10, 4);
      run(8'h10, 4, 1000, 1'b0, 1'b0);
      make_pre(8'h30, 2);
      run(8'h30, 2, 6, 1'b0, 1'b1);

      make_pre(8'h50, 3);
      run(8'h50, 3, 1, 1'b1, 1'b0);

      make_pre(8'h60, 2);
      run(8'h60, 2, TMO, 1'b0, 1'b0);

      for (int r = 0; r < 12; r++) begin
         ready_mode = $urandom_range(0, 2);
         cnt = $urandom_range(0, 8);
         dly = $urandom_range(1, TMO + 4);
         ins = (dly == 1) && ($urandom_range(0, 1) == 1);
         pk  = (dly >= 3) && ($urandom_range(0, 1) == 1);
         rd_base = AW'($urandom);
         make_pre(rd_base, cnt);
         run(rd_base, cnt, dly, ins, pk);
      end
      ready_mode = 0;

      // reset during RUN
      wait_idle("rst_run_idle");
      s_done = cnt_done;
      make_pre(8'h70, 2);
      go_and_load(8'h70, 2, 1);
      n = 0;
      while (bus.mem_own && n < 20) begin
         tick();
         n++;
      end
      check("rst_run_entered", 32'(bus.mem_own), 0);
      repeat (3) tick();
      #1;
      reset = 1'b1;
      #1;
      reset_checks("rst_run");
      sb.delete();
      tick();
      reset = 1'b0;
      repeat (4) tick();
      check("rst_run_no_done", 32'(cnt_done - s_done), 0);
      check("rst_run_idle", 32'(busy), 0);

      // reset during READ
      s_done = cnt_done;
      s_words = cnt_words;
      make_pre(8'h80, 8);
      go_and_load(8'h80, 8, 2);
      n = 0;
      while (bus.mem_own && n < 20) begin
         tick();
         n++;
      end
      dut_done = 1'b1;
      tick();
      dut_done = 1'b0;
      n = 0;
      while (cnt_words - s_words < 2 && n < 20) begin
         tick();
         n++;
      end
      check("rst_read_streaming", 32'(bus.res_valid), 1);
      #1;
      reset = 1'b1;
      #1;
      reset_checks("rst_read");
      sb.delete();
      s_words = cnt_words;
      tick();
      reset = 1'b0;
      repeat (4) tick();
      check("rst_read_no_words", 32'(cnt_words - s_words), 0);
      check("rst_read_no_done", 32'(cnt_done - s_done), 0);

      make_pre(8'h90, 3);
      run(8'h90, 3, 4, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_time_limit: simulation still running, required finish");
      $fatal(1);
   end

endmodule
